// File: rtl/riscv_mc_control.sv
// riscv_mc_control: multi-cycle RV32I control FSM driving datapath enables, mux selects and ALU op
module riscv_mc_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [3:0]  flags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ImmSrc,
  output logic [3:0]  ALUcontrol,
  output logic [3:0]  state
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
    ALUWB, BRANCH, JAL, JALR, JALRLINK, LUI, AUIPC
  } state_t;
  state_t cur, nxt;
  logic [6:0] op;
  logic [2:0] f3;
  logic       f7, v, c, n, z, taken, pcw, irw, mw, rw;
  logic [3:0] funct;
  logic       unused_bits;
  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[30];
  assign {v, c, n, z} = flags;
  assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};
  assign state = cur;
  // write enables are killed combinationally while reset is held
  assign PCWrite  = pcw & ~reset;
  assign IRWrite  = irw & ~reset;
  assign MemWrite = mw & ~reset;
  assign RegWrite = rw & ~reset;
  // immediate format follows the opcode in every state
  always_comb
    ImmSrc = (op == 7'b0100011) ? 3'b001 :
             (op == 7'b1100011) ? 3'b010 :
             (op == 7'b1101111) ? 3'b011 :
             (op == 7'b0110111 || op == 7'b0010111) ? 3'b100 : 3'b000;
  // ALU operation for register and immediate arithmetic
  always_comb begin
    case (f3)
      3'b000:  funct = (cur == EXECR && f7) ? 4'b0001 : 4'b0000;
      3'b001:  funct = 4'b0110;
      3'b010:  funct = 4'b0101;
      3'b011:  funct = 4'b1001;
      3'b100:  funct = 4'b0100;
      3'b101:  funct = f7 ? 4'b1000 : 4'b0111;
      3'b110:  funct = 4'b0011;
      default: funct = 4'b0010;
    endcase
  end
  // branch condition from the flags of the rs1-rs2 subtraction
  always_comb begin
    case (f3)
      3'b000:  taken = z;
      3'b001:  taken = ~z;
      3'b100:  taken = n ^ v;
      3'b101:  taken = ~(n ^ v);
      3'b110:  taken = ~c;
      3'b111:  taken = c;
      default: taken = 1'b0;
    endcase
  end
  // Moore outputs and next state per state
  always_comb begin
    nxt = FETCH;
    pcw = 1'b0;
    irw = 1'b0;
    mw = 1'b0;
    rw = 1'b0;
    AdrSrc = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA = 2'b00;
    ALUSrcB = 2'b00;
    ALUcontrol = 4'b0000;
    case (cur)
      FETCH: begin
        irw = 1'b1;
        pcw = 1'b1;
        ALUSrcB = 2'b10;
        ResultSrc = 2'b10;
        nxt = DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        nxt = (op == 7'b0000011 || op == 7'b0100011) ? MEMADR :
              (op == 7'b0110011) ? EXECR :
              (op == 7'b0010011) ? EXECI :
              (op == 7'b1100011) ? BRANCH :
              (op == 7'b1101111) ? JAL :
              (op == 7'b1100111) ? JALR :
              (op == 7'b0110111) ? LUI :
              (op == 7'b0010111) ? AUIPC : FETCH;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        nxt = (op == 7'b0000011) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        nxt = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        rw = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mw = 1'b1;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        ALUcontrol = funct;
        nxt = ALUWB;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUcontrol = funct;
        nxt = ALUWB;
      end
      ALUWB: rw = 1'b1;
      BRANCH: begin
        ALUSrcA = 2'b10;
        ALUcontrol = 4'b0001;
        pcw = taken;
      end
      JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pcw = 1'b1;
        nxt = ALUWB;
      end
      JALR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ResultSrc = 2'b10;
        pcw = 1'b1;
        nxt = JALRLINK;
      end
      JALRLINK: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        ResultSrc = 2'b10;
        rw = 1'b1;
      end
      LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
        nxt = ALUWB;
      end
      AUIPC: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        nxt = ALUWB;
      end
      default: ;
    endcase
  end
  // state register
  always_ff @(posedge clk)
    cur <= reset ? FETCH : nxt;
endmodule

// File: tb/tb_riscv_mc_control.sv
// tb_riscv_mc_control: per-instruction micro-op sequence checks with random and directed instructions
module tb_riscv_mc_control;
  logic clk = 1'b0, reset = 1'b1;
  logic [31:0] instr = 32'h0;
  logic [3:0] flags = 4'h0;
  logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUcontrol, state;
  int n_cmp = 0, n_bad = 0;

  localparam logic [3:0] S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3, S_MEMWB = 4,
    S_MEMWRITE = 5, S_EXECR = 6, S_EXECI = 7, S_ALUWB = 8, S_BRANCH = 9, S_JAL = 10,
    S_JALR = 11, S_JALRLINK = 12, S_LUI = 13, S_AUIPC = 14;
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
    OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
    OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

  // expected per-cycle control word: state, {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite}, ResultSrc, A, B, ALU op
  typedef struct packed {
    logic [3:0] st;
    logic [4:0] we;
    logic [1:0] rs, a, b;
    logic [3:0] alu;
  } step_t;

  riscv_mc_control dut (
    .clk(clk), .reset(reset), .instr(instr), .flags(flags),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUcontrol(ALUcontrol), .state(state)
  );

  always #5 clk = ~clk;

  function automatic step_t mk(input logic [3:0] st, input logic [4:0] we, input logic [1:0] rs,
                               input logic [1:0] a, input logic [1:0] b, input logic [3:0] alu);
    mk = {st, we, rs, a, b, alu};
  endfunction

  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic f7, input logic isr);
    logic [3:0] t [8];
    t = '{4'd0, 4'd6, 4'd5, 4'd9, 4'd4, 4'd7, 4'd3, 4'd2};
    if (f3 == 3'd0 && isr && f7) return 4'd1;
    if (f3 == 3'd5 && f7) return 4'd8;
    return t[f3];
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    if (op == OP_SW) return 3'b001;
    if (op == OP_BR) return 3'b010;
    if (op == OP_JAL) return 3'b011;
    if (op == OP_LUI || op == OP_AUIPC) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic known(input logic [6:0] op);
    return op inside {OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
  endfunction

  // builds the instruction's cycle-by-cycle expectation and checks it; entered just after a FETCH edge
  task automatic run_instr(input logic [31:0] ins, input logic [3:0] fl, input logic tk);
    step_t q[$];
    step_t wb;
    logic [6:0] op;
    logic [2:0] f3;
    logic [22:0] obs, exp;
    op = ins[6:0];
    f3 = ins[14:12];
    instr = ins;
    flags = fl;
    wb = mk(S_ALUWB, 5'b00001, 2'b00, 2'b00, 2'b00, 4'd0);
    q.push_back(mk(S_FETCH, 5'b10010, 2'b10, 2'b00, 2'b10, 4'd0));
    q.push_back(mk(S_DECODE, 5'b00000, 2'b00, 2'b01, 2'b01, 4'd0));
    if (op == OP_LW || op == OP_SW)
      q.push_back(mk(S_MEMADR, 5'b00000, 2'b00, 2'b10, 2'b01, 4'd0));
    if (op == OP_LW) begin
      q.push_back(mk(S_MEMREAD, 5'b01000, 2'b00, 2'b00, 2'b00, 4'd0));
      q.push_back(mk(S_MEMWB, 5'b00001, 2'b01, 2'b00, 2'b00, 4'd0));
    end
    if (op == OP_SW) q.push_back(mk(S_MEMWRITE, 5'b01100, 2'b00, 2'b00, 2'b00, 4'd0));
    if (op == OP_R) q.push_back(mk(S_EXECR, 5'b00000, 2'b00, 2'b10, 2'b00, alu_of(f3, ins[30], 1'b1)));
    if (op == OP_I) q.push_back(mk(S_EXECI, 5'b00000, 2'b00, 2'b10, 2'b01, alu_of(f3, ins[30], 1'b0)));
    if (op == OP_BR) q.push_back(mk(S_BRANCH, {tk, 4'b0000}, 2'b00, 2'b10, 2'b00, 4'd1));
    if (op == OP_JAL) q.push_back(mk(S_JAL, 5'b10000, 2'b00, 2'b01, 2'b10, 4'd0));
    if (op == OP_JALR) begin
      q.push_back(mk(S_JALR, 5'b10000, 2'b10, 2'b10, 2'b01, 4'd0));
      q.push_back(mk(S_JALRLINK, 5'b00001, 2'b10, 2'b01, 2'b10, 4'd0));
    end
    if (op == OP_LUI) q.push_back(mk(S_LUI, 5'b00000, 2'b00, 2'b11, 2'b01, 4'd0));
    if (op == OP_AUIPC) q.push_back(mk(S_AUIPC, 5'b00000, 2'b00, 2'b01, 2'b01, 4'd0));
    if (op inside {OP_R, OP_I, OP_JAL, OP_LUI, OP_AUIPC}) q.push_back(wb);
    foreach (q[i]) begin
      @(negedge clk);
      obs = {state, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ALUcontrol, ImmSrc};
      exp = {q[i], imm_of(op)};
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL step%0d instr=%h: got %h want %h", i, ins, obs, exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_writes_off(input string nm);
    @(negedge clk);
    n_cmp++;
    if ({PCWrite, IRWrite, MemWrite, RegWrite} !== 4'b0) begin
      n_bad++;
      $display("FAIL %s: writes got %b want 0000", nm, {PCWrite, IRWrite, MemWrite, RegWrite});
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) check_writes_off("reset_hold");
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_rtype;
    run_instr(32'h40B50533, 4'h0, 1'b0);
    run_instr(32'h00B50533, 4'h0, 1'b0);
  endtask

  task automatic test_itype;
    run_instr(32'h4030D093, 4'h0, 1'b0);
    run_instr(32'h00108093, 4'h0, 1'b0);
  endtask

  task automatic test_mem;
    run_instr(32'h00002283, 4'h0, 1'b0);
    run_instr(32'h00502023, 4'h0, 1'b0);
  endtask

  function automatic logic [31:0] br(input logic [2:0] f3);
    return {17'h0, f3, 5'h0, OP_BR};
  endfunction

  task automatic test_branch;
    run_instr(br(3'b100), 4'b1000, 1'b1);
    run_instr(br(3'b111), 4'b0000, 1'b0);
    run_instr(br(3'b001), 4'b0001, 1'b0);
    run_instr(br(3'b010), 4'b1111, 1'b0);
    run_instr(br(3'b000), 4'b0001, 1'b1);
    run_instr(br(3'b110), 4'b0000, 1'b1);
  endtask

  task automatic test_jumps;
    run_instr(32'h000080E7, 4'h0, 1'b0);
    run_instr(32'h008000EF, 4'h0, 1'b0);
    run_instr(32'h0000007F, 4'h0, 1'b0);
  endtask

  task automatic test_reset_mid;
    instr = 32'h40B50533;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_writes_off("reset_mid");
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    run_instr(32'h40B50533, 4'h0, 1'b0);
  endtask

  task automatic test_random;
    logic [6:0] ops [9];
    logic [31:0] ins, a, b, d;
    logic [3:0] fl;
    logic tk;
    ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    for (int k = 0; k < 300; k++) begin
      ins = $urandom;
      fl = 4'($urandom);
      tk = 1'b0;
      if ($urandom_range(0, 9) == 0) begin
        while (known(ins[6:0])) ins[6:0] = 7'($urandom);
      end else ins[6:0] = ops[$urandom_range(0, 8)];
      if (ins[6:0] == OP_BR) begin
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? a : $urandom;
        d = a - b;
        fl = {(a[31] != b[31]) && (d[31] != a[31]), a >= b, d[31], d == 0};
        case (ins[14:12])
          3'b000: tk = a == b;
          3'b001: tk = a != b;
          3'b100: tk = $signed(a) < $signed(b);
          3'b101: tk = $signed(a) >= $signed(b);
          3'b110: tk = a < b;
          3'b111: tk = a >= b;
          default: tk = 1'b0;
        endcase
      end
      run_instr(ins, fl, tk);
    end
  endtask

  initial begin
    test_reset;
    test_rtype;
    test_itype;
    test_mem;
    test_branch;
    test_jumps;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/riscv_mc_control.md
Name: riscv_mc_control

Overview:
Multi-cycle control FSM for the RISCV32I core, and the initiator that drives the ALU.
- Decodes the latched instruction, sequences fetch/decode/execute/memory/writeback and emits every datapath enable and mux select.
- Drives the 4-bit ALU operation code and consumes the ALU's {v,c,n,z} flags to resolve conditional branches.
- Sits between the instruction register and the datapath, register file and unified memory.

Parameters:
none

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  synchronous, active-high
- instr  in  32  instruction register contents (opcode [6:0], funct3 [14:12], funct7b5 [30])
- flags  in  4  ALU flags {v,c,n,z}, combinational from the current ALU operation
- PCWrite  out  1  PC register load enable
- AdrSrc  out  1  memory address: 0=PC, 1=Result
- MemWrite  out  1  memory write enable
- IRWrite  out  1  instruction/OldPC register load enable
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  00=ALUOut, 01=read data, 10=ALU result
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1 reg, 11=zero
- ALUSrcB  out  2  00=rs2 reg, 01=immediate, 10=constant 4
- ImmSrc  out  3  000=I, 001=S, 010=B, 011=J, 100=U
- ALUcontrol  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sll, 0111 srl, 1000 sra, 1001 sltu
- state  out  4  current state, for debug

Behaviour:
- One clock (clk). Synchronous active-high reset (reset): at a rising edge with reset=1, state<=FETCH.
- While reset=1: PCWrite, IRWrite, MemWrite and RegWrite are forced to 0 combinationally. Reset mid-instruction abandons that instruction with no further writes.
- Outputs are Moore functions of state. Exceptions:
  - ImmSrc decodes from opcode: lw/jalr/OP-IMM=I, sw=S, branch=B, jal=J, lui/auipc=U, else 000.
  - ALUcontrol is decoded in "funct" states (below).
  - PCWrite in BRANCH depends on flags.
- Any unlisted output is 0; ALUcontrol defaults to add.
- States and actions:
  - FETCH: AdrSrc=0, IRWrite=1, A=PC, B=4, add, ResultSrc=10, PCWrite=1 -> DECODE.
  - DECODE: A=OldPC, B=imm, add (branch/jal target captured into ALUOut). Next state by opcode: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR; 0110111 -> LUI; 0010111 -> AUIPC; other -> FETCH (nop, PC already advanced).
  - MEMADR: A=rs1, B=imm, add -> MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: AdrSrc=1, ResultSrc=00 -> MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 -> FETCH.
  - EXECR: A=rs1, B=rs2, funct -> ALUWB.
  - EXECI: A=rs1, B=imm, funct -> ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
  - BRANCH: A=rs1, B=rs2, sub, ResultSrc=00, PCWrite=taken -> FETCH.
  - JAL: A=OldPC, B=4, add, ResultSrc=00, PCWrite=1 -> ALUWB (rd<=OldPC+4).
  - JALR: A=rs1, B=imm, add, ResultSrc=10, PCWrite=1 -> JALRLINK. Bit 0 of the target is not cleared.
  - JALRLINK: A=OldPC, B=4, add, ResultSrc=10, RegWrite=1 -> FETCH.
  - LUI: A=zero, B=imm -> ALUWB.
  - AUIPC: A=OldPC, B=imm -> ALUWB.
- Funct decode by funct3:
  - 000: sub only if EXECR and funct7b5=1, else add.
  - 001 sll; 010 slt; 011 sltu; 100 xor; 110 or; 111 and.
  - 101: sra if funct7b5=1, else srl (both EXECR and EXECI).
- Branch taken, evaluated on the flags of the same-cycle sub (c=1 means rs1>=rs2 unsigned):
  - beq 000: z. bne 001: ~z.
  - blt 100: n^v. bge 101: ~(n^v).
  - bltu 110: ~c. bgeu 111: c.
  - funct3 010/011: not taken.
- CPI: lw 5, sw 4, R/I/lui/auipc/jal 4, jalr 4, branch 3.

Test Plan:
- Reset held 3 cycles mid-EXECR -> all write enables 0 throughout; state=FETCH after release; FETCH asserts IRWrite=1, PCWrite=1, ALUSrcB=10.
- instr=0x40B50533 (sub) -> states FETCH, DECODE, EXECR (ALUcontrol=0001, ALUSrcB=00), ALUWB (RegWrite=1), FETCH.
- instr=0x4030D093 (srai) -> EXECI with ALUcontrol=1000, ImmSrc=000. instr=0x00108093 (addi) -> ALUcontrol=0000.
- instr=0x00002283 (lw) -> 5 cycles; MEMREAD AdrSrc=1; MEMWB ResultSrc=01, RegWrite=1. instr=0x00502023 (sw) -> MEMWRITE, MemWrite=1, RegWrite never 1.
- BRANCH flags sweep: blt with flags=1000 (v=1, n=0) -> PCWrite=1. bgeu with c=0 -> PCWrite=0. bne with z=1 -> 0. funct3=010 -> 0.
- jalr (0x000080E7) -> JALR with PCWrite=1, ResultSrc=10; JALRLINK with RegWrite=1. Opcode 0x7F -> DECODE to FETCH with no writes.
